// File: rtl/guess_entry.sv
// guess_entry -- player-side guess source for the digit-guessing game.
//
// Collects digits from debounced keypad strobes into a packed guess and
// presents it to the scorer. After the scorer settles it samples the
// correct/wrong-place counts, counts the turn and tracks win/lose.
//
// Optional feature macro: GUESS_UNIQUE_DIGITS_EN
//   defined   : a digit equal to one already entered is rejected
//   undefined : repeated digits are accepted
//
// Ports
//   clk                 in  system clock
//   reset               in  asynchronous, active-low reset
//   digit_in            in  digit value, qualified by digit_stb
//   digit_stb           in  1-cycle pulse: append digit_in
//   backspace_stb       in  1-cycle pulse: delete last digit
//   submit_stb          in  1-cycle pulse: submit the guess
//   new_game_stb        in  1-cycle pulse: restart from DONE
//   correct_place_count in  scorer result
//   wrong_place_count   in  scorer result
//   guess               out packed guess, first digit entered in the top nibble
//   guess_valid         out 1-cycle pulse when a guess is submitted
//   entry_count         out digits entered so far
//   turn_count          out completed turns
//   last_correct        out sampled correct_place_count
//   last_wrong          out sampled wrong_place_count
//   busy                out high while waiting on the scorer
//   reject              out 1-cycle pulse on an illegal action
//   won, lost           out sticky game result
module guess_entry #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned DIGIT_MAX = 9,
  parameter int unsigned MAX_TURNS = 10,
  parameter int unsigned CHECK_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIGIT_W-1:0]             digit_in,
  input  logic                           digit_stb,
  input  logic                           backspace_stb,
  input  logic                           submit_stb,
  input  logic                           new_game_stb,
  input  logic [3:0]                     correct_place_count,
  input  logic [3:0]                     wrong_place_count,
  output logic [DIGITS*DIGIT_W-1:0]      guess,
  output logic                           guess_valid,
  output logic [$clog2(DIGITS+1)-1:0]    entry_count,
  output logic [3:0]                     turn_count,
  output logic [3:0]                     last_correct,
  output logic [3:0]                     last_wrong,
  output logic                           busy,
  output logic                           reject,
  output logic                           won,
  output logic                           lost
);

  localparam int unsigned GW  = DIGITS * DIGIT_W;
  localparam int unsigned CW  = $clog2(DIGITS + 1);
  localparam int unsigned WCW = $clog2(CHECK_LAT + 2);

  localparam logic [CW-1:0]      FULL      = CW'(DIGITS);
  localparam logic [DIGIT_W-1:0] DMAX      = DIGIT_W'(DIGIT_MAX);
  localparam logic [3:0]         ALL_RIGHT = 4'(DIGITS);
  localparam logic [3:0]         TURN_LIM  = 4'(MAX_TURNS);
  localparam logic [WCW-1:0]     WAIT_LAST = WCW'(CHECK_LAT);

  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_WAIT  = 2'd1,
    S_SCORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [WCW-1:0]       wait_cnt, wait_nxt;
  logic [GW-1:0]        guess_nxt;
  logic [CW-1:0]        entry_nxt;
  logic [3:0]           turn_nxt, lc_nxt, lw_nxt, turn_inc;
  logic                 gv_nxt, rej_nxt, won_nxt, lost_nxt;
  logic                 dup;

`ifdef GUESS_UNIQUE_DIGITS_EN
  // The most recent digit sits in the low nibble, so the entered digits
  // occupy nibbles 0 .. entry_count-1.
  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i < 32'(entry_count) && guess[i*DIGIT_W +: DIGIT_W] == digit_in)
        dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign busy     = (state == S_WAIT);
  assign turn_inc = turn_count + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_ENTRY;
      wait_cnt     <= '0;
      guess        <= '0;
      entry_count  <= '0;
      turn_count   <= '0;
      last_correct <= '0;
      last_wrong   <= '0;
      guess_valid  <= 1'b0;
      reject       <= 1'b0;
      won          <= 1'b0;
      lost         <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_nxt;
      guess        <= guess_nxt;
      entry_count  <= entry_nxt;
      turn_count   <= turn_nxt;
      last_correct <= lc_nxt;
      last_wrong   <= lw_nxt;
      guess_valid  <= gv_nxt;
      reject       <= rej_nxt;
      won          <= won_nxt;
      lost         <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    guess_nxt = guess;
    entry_nxt = entry_count;
    turn_nxt  = turn_count;
    lc_nxt    = last_correct;
    lw_nxt    = last_wrong;
    gv_nxt    = 1'b0;
    rej_nxt   = 1'b0;
    won_nxt   = won;
    lost_nxt  = lost;

    unique case (state)
      S_ENTRY: begin
        // submit > backspace > digit; lower strobes in the same cycle drop
        if (submit_stb) begin
          if (entry_count == FULL) begin
            gv_nxt    = 1'b1;
            wait_nxt  = '0;
            state_nxt = S_WAIT;
          end else begin
            rej_nxt = 1'b1;
          end
        end else if (backspace_stb) begin
          if (entry_count != '0) begin
            guess_nxt = guess >> DIGIT_W;
            entry_nxt = entry_count - CW'(1);
          end
        end else if (digit_stb) begin
          if (entry_count == FULL || digit_in > DMAX || dup) begin
            rej_nxt = 1'b1;
          end else begin
            guess_nxt = (guess << DIGIT_W) | {{(GW-DIGIT_W){1'b0}}, digit_in};
            entry_nxt = entry_count + CW'(1);
          end
        end
      end

      // Guess is held so the scorer sees a stable input for CHECK_LAT+1 cycles.
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = S_SCORE;
        else                       wait_nxt  = wait_cnt + WCW'(1);
      end

      S_SCORE: begin
        lc_nxt   = correct_place_count;
        lw_nxt   = wrong_place_count;
        turn_nxt = turn_inc;
        if (correct_place_count == ALL_RIGHT) begin
          won_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else if (turn_inc == TURN_LIM) begin
          lost_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          guess_nxt = '0;
          entry_nxt = '0;
          state_nxt = S_ENTRY;
        end
      end

      S_DONE: begin
        if (new_game_stb) begin
          guess_nxt = '0;
          entry_nxt = '0;
          turn_nxt  = '0;
          lc_nxt    = '0;
          lw_nxt    = '0;
          won_nxt   = 1'b0;
          lost_nxt  = 1'b0;
          state_nxt = S_ENTRY;
        end
      end

      default: state_nxt = S_ENTRY;
    endcase
  end

endmodule
